// File: rtl/fetch_unit.sv
// fetch_unit: LEGv8 fetch stage with a DEPTH-entry {pc,instr} queue and branch redirect.
// Optional FETCH_ALIGN_CHECK_EN flags and word-aligns misaligned redirect targets.
module fetch_unit #(
  parameter int ADDR_W = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect,
  input  logic [1:0]         redirect_src,
  input  logic [ADDR_W-1:0]  br_base_pc,
  input  logic [ADDR_W-1:0]  uncond_offset,
  input  logic [ADDR_W-1:0]  cond_offset,
  input  logic [ADDR_W-1:0]  reg_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               misalign_fault
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, target, load_pc;
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [INSTR_W-1:0] instr_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0] count_q, count_d;
  logic pop, push, redir;
  always_comb begin
    redir = redirect & |redirect_src;
    target = redirect_src == 2'b01 ? br_base_pc + uncond_offset :
             redirect_src == 2'b10 ? br_base_pc + cond_offset : reg_target;
`ifdef FETCH_ALIGN_CHECK_EN
    load_pc = {target[ADDR_W-1:2], 2'b00};
`else
    load_pc = target;
`endif
    out_valid = count_q != '0;
    pop = out_valid & out_ready;
    push = count_q < (PW+1)'(DEPTH) | pop;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    fetch_pc_d = push ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
  end
  assign imem_addr = fetch_pc_q;
  assign imem_req = push;
  assign out_pc = pc_q[rd_ptr_q];
  assign out_instr = out_valid ? instr_q[rd_ptr_q] : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else if (redir) begin
      fetch_pc_q <= load_pc;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr_q] <= fetch_pc_q;
        instr_q[wr_ptr_q] <= imem_instr;
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      fetch_pc_q <= fetch_pc_d;
      count_q <= count_d;
    end
  end
`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk) fault_q <= reset & redir & |target[1:0];
  assign misalign_fault = fault_q;
`else
  assign misalign_fault = 1'b0;
`endif
endmodule
